// File: rtl/riscv_single_cycle_pkg.sv
// rtl/riscv_single_cycle_pkg.sv - shared encodings for the single-cycle data memory
package riscv_single_cycle_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [11:0] MMIO_TOHOST   = 12'h000;
    localparam logic [11:0] MMIO_CYCLE_LO = 12'h004;
    localparam logic [11:0] MMIO_CYCLE_HI = 12'h008;
    localparam logic [11:0] MMIO_STATUS   = 12'h00C;

    localparam int STATUS_ERR_BIT  = 0;
    localparam int STATUS_HALT_BIT = 1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

endpackage

// File: rtl/riscv_single_cycle_lsu_align.sv
// rtl/riscv_single_cycle_lsu_align.sv - store lane/shift, load extract/extend, misalign check
import riscv_single_cycle_pkg::*;

module riscv_single_cycle_lsu_align (
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_mmio,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata,
    output logic        misalign
);

    size_e       size;
    logic [31:0] shifted;

    always_comb begin
        size     = size_e'(funct3[1:0]);
        misalign = 1'b0;
        be       = 4'b0000;
        wword    = wdata;
        ldata    = '0;
        shifted  = rword >> {addr_lo, 3'b000};

        case (size)
            SZ_HALF: misalign = addr_lo[0];
            SZ_WORD: misalign = |addr_lo;
            SZ_BAD:  misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
        // MMIO registers are word-only
        if (is_mmio && size != SZ_WORD)
            misalign = 1'b1;

        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                wword = wdata;
            end
            default: be = 4'b0000;
        endcase

        case (funct3)
            F3_LB:   ldata = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  ldata = {24'd0, shifted[7:0]};
            F3_LH:   ldata = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  ldata = {16'd0, shifted[15:0]};
            F3_LW:   ldata = rword;
            default: ldata = '0;
        endcase

        if (misalign) begin
            be    = 4'b0000;
            ldata = '0;
        end
    end

endmodule

// File: rtl/riscv_single_cycle_dmem.sv
// rtl/riscv_single_cycle_dmem.sv - data RAM plus tohost/cycle/status MMIO for the RV32E core
import riscv_single_cycle_pkg::*;

module riscv_single_cycle_dmem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        halt,
    output logic [31:0] tohost,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];
    logic [63:0] cycle;
    logic        is_mmio;
    logic [AW-1:0] idx;
    logic [31:0] mmio_word;
    logic [31:0] rword;
    logic [3:0]  be;
    logic [31:0] wword;
    logic [31:0] ldata;
    logic        misalign;
    logic        ram_wr;
    logic        mmio_wr;

    assign is_mmio = (addr[31:12] == MMIO_BASE[31:12]);
    assign idx     = addr[2 +: AW];
    assign ram_wr  = we && !is_mmio && !halt;
    assign mmio_wr = we && is_mmio && !misalign && !halt;

    always_comb begin
        mmio_word = '0;
        case (addr[11:0])
            MMIO_TOHOST:   mmio_word = tohost;
            MMIO_CYCLE_LO: mmio_word = cycle[31:0];
            MMIO_CYCLE_HI: mmio_word = cycle[63:32];
            MMIO_STATUS: begin
                mmio_word[STATUS_ERR_BIT]  = misalign_err;
                mmio_word[STATUS_HALT_BIT] = halt;
            end
            default: mmio_word = '0;
        endcase
    end

    assign rword = is_mmio ? mmio_word : mem[idx];
    assign rdata = re ? ldata : 32'd0;

    riscv_single_cycle_lsu_align u_align (
        .addr_lo  (addr[1:0]),
        .funct3   (funct3),
        .is_mmio  (is_mmio),
        .wdata    (wdata),
        .rword    (rword),
        .be       (be),
        .wword    (wword),
        .ldata    (ldata),
        .misalign (misalign)
    );

    // RAM has no reset; gating on rst drops a store caught by a mid-cycle reset
    always_ff @(posedge clk) begin
        if (rst && ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle        <= '0;
            halt         <= 1'b0;
            tohost       <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (!halt)
                cycle <= cycle + 64'd1;
            if ((re || we) && misalign)
                misalign_err <= 1'b1;
            if (mmio_wr && addr[11:0] == MMIO_TOHOST) begin
                tohost <= wdata;
                halt   <= 1'b1;
            end
            if (mmio_wr && addr[11:0] == MMIO_STATUS && wdata[STATUS_ERR_BIT])
                misalign_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_single_cycle_dmem.sv
// tb/tb_riscv_single_cycle_dmem.sv - directed self-checking bench for riscv_single_cycle_dmem
module tb_riscv_single_cycle_dmem;

    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        halt;
    logic [31:0] tohost;
    logic        misalign_err;

    int total;
    int bad;
    int edges;
    int rel_mark;

    riscv_single_cycle_dmem dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .re           (re),
        .we           (we),
        .funct3       (funct3),
        .rdata        (rdata),
        .halt         (halt),
        .tohost       (tohost),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edges = 0;
    always @(posedge clk) edges = edges + 1;

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        @(negedge clk);
        addr = a; wdata = d; funct3 = f; we = 1'b1; re = 1'b0;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f, output logic [31:0] d);
        @(negedge clk);
        addr = a; funct3 = f; re = 1'b1; we = 1'b0;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        re = 1'b0;
    endtask

    task automatic test_reset;
        total++;
        if (rdata !== 32'd0 || halt !== 1'b0 || tohost !== 32'd0 || misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: rdata=%h halt=%b tohost=%h err=%b want all 0", rdata, halt, tohost, misalign_err);
        end
    endtask

    task automatic test_cycle_count;
        logic [31:0] d;
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        rel_mark = edges;
        repeat (5) @(posedge clk);
        do_load(MB + 32'h4, 3'b010, d);
        total++;
        if (d !== 32'd5) begin
            bad++;
            $display("FAIL cycle_lo_after_5: got %h want %h", d, 32'd5);
        end
        do_load(MB + 32'h8, 3'b010, d);
        total++;
        if (d !== 32'd0) begin
            bad++;
            $display("FAIL cycle_hi_small: got %h want 0", d);
        end
    endtask

    task automatic test_sizes;
        logic [31:0] d;
        do_store(32'h10, 32'hDEADBEEF, 3'b010);
        do_store(32'h13, 32'h0000007F, 3'b000);
        do_load(32'h10, 3'b010, d);
        total++;
        if (d !== 32'h7FADBEEF) begin bad++; $display("FAIL lw_after_sb: got %h want 7fadbeef", d); end
        do_load(32'h11, 3'b000, d);
        total++;
        if (d !== 32'hFFFFFFBE) begin bad++; $display("FAIL lb_sign: got %h want ffffffbe", d); end
        do_load(32'h11, 3'b100, d);
        total++;
        if (d !== 32'h000000BE) begin bad++; $display("FAIL lbu_zero: got %h want 000000be", d); end
        do_load(32'h12, 3'b001, d);
        total++;
        if (d !== 32'h00007FAD) begin bad++; $display("FAIL lh_pos: got %h want 00007fad", d); end
        do_store(32'h12, 32'h1234CAFE, 3'b001);
        do_load(32'h12, 3'b001, d);
        total++;
        if (d !== 32'hFFFFCAFE) begin bad++; $display("FAIL lh_neg: got %h want ffffcafe", d); end
        do_load(32'h10, 3'b101, d);
        total++;
        if (d !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_low: got %h want 0000beef", d); end
    endtask

    task automatic test_read_write_same;
        logic [31:0] d;
        @(negedge clk);
        addr = 32'h10; wdata = 32'h0; funct3 = 3'b010; we = 1'b1; re = 1'b1;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        total++;
        if (d !== 32'hCAFEBEEF) begin bad++; $display("FAIL rw_prewrite: got %h want cafebeef", d); end
        do_load(32'h10, 3'b010, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rw_committed: got %h want 0", d); end
    endtask

    task automatic test_misalign;
        logic [31:0] d;
        do_load(32'h12, 3'b010, d);
        total++;
        if (d !== 32'd0 || misalign_err !== 1'b1) begin
            bad++;
            $display("FAIL lw_misaligned: rdata=%h err=%b want 0 and 1", d, misalign_err);
        end
        do_store(32'h20, 32'h11223344, 3'b010);
        do_store(32'h21, 32'h0000BEEF, 3'b001);
        do_load(32'h20, 3'b010, d);
        total++;
        if (d !== 32'h11223344) begin bad++; $display("FAIL sh_misaligned_nowrite: got %h want 11223344", d); end
        do_load(MB + 32'hC, 3'b010, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL status_err: got %h want 1", d); end
        do_store(MB + 32'hC, 32'h1, 3'b010);
        total++;
        if (misalign_err !== 1'b0) begin bad++; $display("FAIL status_w1c: err=%b want 0", misalign_err); end
        do_load(MB + 32'h4, 3'b001, d);
        total++;
        if (d !== 32'd0 || misalign_err !== 1'b1) begin
            bad++;
            $display("FAIL mmio_half: rdata=%h err=%b want 0 and 1", d, misalign_err);
        end
        do_store(MB + 32'hC, 32'h1, 3'b010);
    endtask

    task automatic test_alias;
        logic [31:0] d;
        do_store(32'h1000, 32'h00001234, 3'b010);
        do_load(32'h0000, 3'b010, d);
        total++;
        if (d !== 32'h00001234) begin bad++; $display("FAIL alias_wrap: got %h want 00001234", d); end
    endtask

    task automatic test_halt;
        logic [31:0] d;
        int frz;
        do_store(MB, 32'h1, 3'b010);
        frz = edges - rel_mark;
        total++;
        if (halt !== 1'b1 || tohost !== 32'h1) begin
            bad++;
            $display("FAIL tohost_write: halt=%b tohost=%h want 1 and 1", halt, tohost);
        end
        repeat (3) @(posedge clk);
        do_load(MB + 32'h4, 3'b010, d);
        total++;
        if (d !== frz) begin bad++; $display("FAIL cycle_frozen: got %0d want %0d", d, frz); end
        do_store(32'h0, 32'hAAAA5555, 3'b010);
        do_load(32'h0, 3'b010, d);
        total++;
        if (d !== 32'h00001234) begin bad++; $display("FAIL store_after_halt: got %h want 00001234", d); end
        do_load(32'h13, 3'b010, d);
        do_store(MB + 32'hC, 32'h1, 3'b010);
        do_load(MB + 32'hC, 3'b010, d);
        total++;
        if (d !== 32'h3) begin bad++; $display("FAIL status_clear_after_halt: got %h want 3", d); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        @(negedge clk);
        addr = MB + 32'h4; funct3 = 3'b010; re = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (halt !== 1'b0 || tohost !== 32'd0 || misalign_err !== 1'b0 || rdata !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: halt=%b tohost=%h err=%b cycle_lo=%h want all 0", halt, tohost, misalign_err, rdata);
        end
        rst = 1'b1;
        #1;
        d = rdata;
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL cycle_lo_first_after_release: got %h want 0", d); end
        @(posedge clk);
        #1;
        re = 1'b0;
        do_load(MB + 32'h8, 3'b010, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL cycle_hi_after_reset: got %h want 0", d); end
    endtask

    initial begin
        total = 0; bad = 0; rel_mark = 0;
        rst = 1'b0; addr = '0; wdata = '0; re = 1'b0; we = 1'b0; funct3 = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_cycle_count;
        test_sizes;
        test_read_write_same;
        test_misalign;
        test_alias;
        test_halt;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_single_cycle_dmem.md
# riscv_single_cycle_dmem

Data-memory responder for the single-cycle RV32E core: the target end of the core's data memory interface. It serves RAM loads and stores with RV32 byte/half/word sizing and sign/zero extension, and a small MMIO window holding a tohost/halt register, a 64-bit cycle counter and a sticky misalignment status. Reads are combinational, to fit the single-cycle datapath. Writes and all state updates commit on the clock edge.

## Interface
- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words; power of two, at least 4.
- `MMIO_BASE`, default 32'h8000_0000: base of the MMIO window. Its low 12 bits must be zero.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `addr`, input, 32: byte address, driven by the core's ALU result.
- `wdata`, input, 32: store data, unshifted rs2 value.
- `re`, input, 1: load request this cycle.
- `we`, input, 1: store request this cycle.
- `funct3`, input, 3: access size and extension, per RV32 load/store encoding.
- `rdata`, output, 32: load data, already aligned and extended; combinational.
- `halt`, output, 1: sticky; set by a tohost write.
- `tohost`, output, 32: last value written to TOHOST.
- `misalign_err`, output, 1: sticky error flag.

## Operation
- **Decode:** the access is MMIO when `addr[31:12] == MMIO_BASE[31:12]`; otherwise it is RAM.
- **RAM indexing:** word index is `addr[2 +: log2(DEPTH_WORDS)]`. Upper address bits are truncated, so accesses alias and wrap.
- **Size rules:**
  - `funct3[1:0]` 00 is a byte access, 01 a half, 10 a word, 11 illegal.
  - For loads, `funct3[2]` = 1 selects zero-extension (LBU/LHU).
  - For stores, `funct3[2]` is ignored.
- **Misaligned access:** a half with `addr[0]`=1, a word with `addr[1:0]`≠0, size 11, or any non-word MMIO access.
  - A misaligned load returns `rdata` 0.
  - A misaligned store writes nothing.
  - Either sets `misalign_err` at the next edge.
- **Stores:**
  - SB writes lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes {`addr[1]`*2 +1 : +0} with `wdata[15:0]`.
  - SW writes all 4 lanes.
  - Unselected lanes are preserved.
- **Loads:** select the byte or half by `addr[1:0]`, then sign- or zero-extend to 32 bits. `rdata` is 0 whenever `re`=0.
- **MMIO map** (offset = `addr[11:0]`):
  - 0x000 TOHOST: RW. A write sets `tohost`=`wdata` and `halt`=1.
  - 0x004 CYCLE_LO: RO.
  - 0x008 CYCLE_HI: RO.
  - 0x00C STATUS: bit0 = `misalign_err`, bit1 = `halt`. A write with `wdata[0]`=1 clears `misalign_err` (write-1-to-clear); other bits are ignored.
  - Unmapped offsets read 0 and ignore writes.
- **Cycle counter:** 64-bit. It increments by 1 every cycle while `halt`=0, wraps from 2^64−1 to 0, and freezes while `halt`=1.
- **After halt:** all stores (RAM and MMIO) are ignored, including the STATUS clear. Loads remain functional. Only `rst` leaves halt.
- **Simultaneous events:**
  - STATUS write-1-to-clear and a new misaligned access in the same cycle cannot occur, because one access is allowed per cycle.
  - If `re` and `we` are both high, the store commits and `rdata` shows the pre-write contents.

## Timing
- Load latency is 0 cycles: `rdata` is valid combinationally in the request cycle from `addr`, `funct3` and `re`.
- Store latency is 1 edge: data is visible to a load in the next cycle.
- `misalign_err`, `halt` and `tohost` update at the edge that ends the offending or writing cycle.
- A CYCLE_LO/CYCLE_HI read returns the pre-edge count. The first cycle after reset release reads 0.
- Reset (asynchronous, active-low) sets:
  - `halt`=0, `tohost`=0, `misalign_err`=0, counter=0.
  - RAM contents are not reset; they retain their values and are X in simulation until written.
  - `rdata` follows `re`, so it is 0 during reset if `re`=0.
- If reset asserts mid-cycle during a store, the store is lost and registers clear immediately.

## Structure
- Package `riscv_single_cycle_pkg` holds:
  - funct3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, `F3_SB`, `F3_SH`, `F3_SW`.
  - MMIO offsets: `MMIO_TOHOST`, `MMIO_CYCLE_LO`, `MMIO_CYCLE_HI`, `MMIO_STATUS`.
  - STATUS bit positions.
- Sub-module `riscv_single_cycle_lsu_align` is combinational. It produces store byte-enables and the shifted store word, the load extract/extend, and the misalign flag. The top level keeps the RAM array, the MMIO registers and the counter.

## Test plan
- **RAM store/load sizes:** SW 0xDEADBEEF @0x10, then SB 0x7F @0x13 → LW @0x10 = 0x7FADBEEF. Then LB @0x11 = 0xFFFFFFBE, LBU @0x11 = 0x000000BE, LH @0x12 = 0x00007FAD.
- **Misaligned accesses:** LW @0x12 → `rdata`=0 and `misalign_err`=1 next cycle. SH @0x21 → RAM word 0x20 unchanged. SW 1 to STATUS → `misalign_err`=0.
- **Aliasing:** with DEPTH_WORDS=1024, SW 0x1234 @0x1000, then LW @0x0000 → 0x1234.
- **Cycle counter and halt:** release reset and idle 5 cycles → LW CYCLE_LO = 5. SW 0x1 to TOHOST → `halt`=1 and `tohost`=1; counter frozen on later reads; subsequent SW @0x0 ignored.
- **Async reset mid-run:** assert `rst` low between edges after halt → `halt`, `tohost`, `misalign_err` and counter are 0 immediately. CYCLE_HI reads 0 after release.
